// File: rtl/ll_frame_tx_if.sv
// ---------------------------------------------------------------------------
// ll_frame_tx_if -- bundle of the command, payload and LocalLink signals of
// the ll_frame_tx block.
//
//   Command  : cmd_valid, cmd_ready, cmd_flag[31:0], cmd_len[LEN_W-1:0]
//   Payload  : pay_data[31:0] (big-endian, byte 0 in [31:24]), pay_valid,
//              pay_ready
//   LocalLink: LLTXD[31:0], LLTXREM[3:0], LLTXSOFN, LLTXEOFN, LLTXSOPN,
//              LLTXEOPN, LLTXSRCRDYN (all active-low flags), LLTXDSTRDYN
//   Status   : frame_done (one-cycle pulse on the last beat of a frame)
//
// Modports: master = the frame transmitter, slave = everything around it.
// ---------------------------------------------------------------------------
interface ll_frame_tx_if #(
  parameter int LEN_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_flag;
  logic [LEN_W-1:0] cmd_len;

  logic [31:0]      pay_data;
  logic             pay_valid;
  logic             pay_ready;

  logic [31:0]      LLTXD;
  logic [3:0]       LLTXREM;
  logic             LLTXSOFN;
  logic             LLTXEOFN;
  logic             LLTXSOPN;
  logic             LLTXEOPN;
  logic             LLTXSRCRDYN;
  logic             LLTXDSTRDYN;

  logic             frame_done;

  modport master (
    input  cmd_valid, cmd_flag, cmd_len, pay_data, pay_valid, LLTXDSTRDYN,
    output cmd_ready, pay_ready, LLTXD, LLTXREM, LLTXSOFN, LLTXEOFN,
           LLTXSOPN, LLTXEOPN, LLTXSRCRDYN, frame_done
  );

  modport slave (
    output cmd_valid, cmd_flag, cmd_len, pay_data, pay_valid, LLTXDSTRDYN,
    input  cmd_ready, pay_ready, LLTXD, LLTXREM, LLTXSOFN, LLTXEOFN,
           LLTXSOPN, LLTXEOPN, LLTXSRCRDYN, frame_done
  );
endinterface

// File: rtl/ll_frame_tx.sv
// ---------------------------------------------------------------------------
// ll_frame_tx -- builds one LocalLink frame per accepted command: eight
// 32-bit header words followed by ceil(len/4) payload words taken from the
// payload stream. The last payload word carries a remainder code and has its
// unused low bytes zeroed. A zero-length command produces a header-only frame
// whose EOF sits on header word 7.
//
// Ports:
//   CPMDMALLCLK : single clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : ll_frame_tx_if.master (command, payload, LocalLink, status)
//
// Header words: 4 = command flag (bit 29 = copy op), 5 = length zero-extended,
// 6 = frame sequence number or 0, all others 0.
//
// Build option: define LL_FRAME_TX_SEQ_EN to carry a 32-bit frame sequence
// number in header word 6 (0 after reset, +1 per completed frame). Without
// it, word 6 is 0 and no sequence register exists.
//
// The outgoing beat lives in a single output register; it only changes when
// it is empty or being transferred, so a stalled sink sees stable outputs.
// ---------------------------------------------------------------------------
module ll_frame_tx #(
  parameter int LEN_W = 16
) (
  input  logic          CPMDMALLCLK,
  input  logic          rst_n,
  ll_frame_tx_if.master bus
);

  typedef enum logic [1:0] {IDLE, HDR, PAY} state_e;

  state_e           r_state, w_next_state;
  logic             r_alive;        // low from reset until the first clock
  logic [2:0]       r_hdr_idx;      // header word currently in the output reg
  logic [31:0]      r_flag;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_words_left;   // payload words not yet pulled in
  logic             r_first_pay;

  // Output register (flags kept active-high internally).
  logic             r_src_rdy;
  logic [31:0]      r_data;
  logic [3:0]       r_rem;
  logic             r_sof, r_eof, r_sop, r_eop;

  logic             w_xfer, w_accept, w_pay_load, w_last_pay;
  logic [LEN_W:0]   w_cmd_sum;
  logic [2:0]       w_idx_next;
  logic [31:0]      w_hdr_word, w_seq, w_mask;
  logic [3:0]       w_last_rem;

  assign w_xfer     = r_src_rdy & ~bus.LLTXDSTRDYN;
  assign w_accept   = bus.cmd_valid & bus.cmd_ready;
  assign w_pay_load = bus.pay_valid & bus.pay_ready;
  assign w_last_pay = (r_words_left == LEN_W'(1));
  assign w_cmd_sum  = {1'b0, bus.cmd_len} + (LEN_W+1)'(3);
  assign w_idx_next = r_hdr_idx + 3'd1;

`ifdef LL_FRAME_TX_SEQ_EN
  logic [31:0] r_seq;

  always_ff @(posedge CPMDMALLCLK or negedge rst_n) begin
    if (!rst_n)              r_seq <= '0;
    else if (bus.frame_done) r_seq <= r_seq + 32'd1;
  end

  assign w_seq = r_seq;
`else
  assign w_seq = '0;
`endif

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; blocking = here would create order-dependent logic.
  always_ff @(posedge CPMDMALLCLK or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // ---------------- FSM: next state ----------------
  // NOTE: the default assignment at the top keeps this block latch-free.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE: if (w_accept) w_next_state = HDR;
      HDR:  if (w_xfer && r_hdr_idx == 3'd7)
              w_next_state = (r_len == '0) ? IDLE : PAY;
      PAY:  if (w_xfer && r_eof) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.cmd_ready  = (r_state == IDLE) && r_alive;
    bus.pay_ready  = (r_state == PAY) && (!r_src_rdy || w_xfer) &&
                     (r_words_left != '0);
    bus.frame_done = w_xfer & r_eof;
  end

  // Content of the header word that follows the one being transferred.
  always_comb begin
    unique case (w_idx_next)
      3'd4:    w_hdr_word = r_flag;
      3'd5:    w_hdr_word = 32'(r_len);
      3'd6:    w_hdr_word = w_seq;
      default: w_hdr_word = '0;
    endcase
  end

  // Byte mask and remainder code of the final payload word (len mod 4).
  always_comb begin
    unique case (r_len[1:0])
      2'd1:    begin w_mask = 32'hFF00_0000; w_last_rem = 4'b0111; end
      2'd2:    begin w_mask = 32'hFFFF_0000; w_last_rem = 4'b0011; end
      2'd3:    begin w_mask = 32'hFFFF_FF00; w_last_rem = 4'b0001; end
      default: begin w_mask = 32'hFFFF_FFFF; w_last_rem = 4'b0000; end
    endcase
  end

  // ---------------- Datapath / output register ----------------
  always_ff @(posedge CPMDMALLCLK or negedge rst_n) begin
    if (!rst_n) begin
      r_alive      <= 1'b0;
      r_hdr_idx    <= '0;
      r_flag       <= '0;
      r_len        <= '0;
      r_words_left <= '0;
      r_first_pay  <= 1'b0;
      r_src_rdy    <= 1'b0;
      r_data       <= '0;
      r_rem        <= '0;
      r_sof        <= 1'b0;
      r_eof        <= 1'b0;
      r_sop        <= 1'b0;
      r_eop        <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      if (w_accept) begin
        // Header word 0 is all zeros and carries SOF.
        r_flag       <= bus.cmd_flag;
        r_len        <= bus.cmd_len;
        r_words_left <= LEN_W'(w_cmd_sum >> 2);
        r_first_pay  <= 1'b1;
        r_hdr_idx    <= '0;
        r_src_rdy    <= 1'b1;
        r_data       <= '0;
        r_rem        <= '0;
        r_sof        <= 1'b1;
        r_eof        <= 1'b0;
        r_sop        <= 1'b0;
        r_eop        <= 1'b0;
      end else if (r_state == HDR && w_xfer) begin
        r_hdr_idx <= w_idx_next;
        r_sof     <= 1'b0;
        if (r_hdr_idx != 3'd7) begin
          r_data <= w_hdr_word;
          r_eof  <= (w_idx_next == 3'd7) && (r_len == '0);
        end else begin
          // Header done; the payload stream refills the register from PAY.
          r_src_rdy <= 1'b0;
          r_data    <= '0;
          r_eof     <= 1'b0;
        end
      end else if (w_pay_load) begin
        r_src_rdy    <= 1'b1;
        r_data       <= w_last_pay ? (bus.pay_data & w_mask) : bus.pay_data;
        r_rem        <= w_last_pay ? w_last_rem : 4'b0000;
        r_sop        <= r_first_pay;
        r_eop        <= w_last_pay;
        r_eof        <= w_last_pay;
        r_first_pay  <= 1'b0;
        r_words_left <= r_words_left - LEN_W'(1);
      end else if (w_xfer) begin
        // Beat left with nothing behind it: bubble.
        r_src_rdy <= 1'b0;
        r_data    <= '0;
        r_rem     <= '0;
        r_sop     <= 1'b0;
        r_eop     <= 1'b0;
        r_eof     <= 1'b0;
      end
    end
  end

  assign bus.LLTXSRCRDYN = ~r_src_rdy;
  assign bus.LLTXD       = r_data;
  assign bus.LLTXREM     = r_rem;
  assign bus.LLTXSOFN    = ~r_sof;
  assign bus.LLTXEOFN    = ~r_eof;
  assign bus.LLTXSOPN    = ~r_sop;
  assign bus.LLTXEOPN    = ~r_eop;

endmodule

// File: tb/tb_ll_frame_tx.sv
// ---------------------------------------------------------------------------
// tb_ll_frame_tx -- directed self-checking bench for ll_frame_tx.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge. Each transferred beat is packed as
// {frame_done, sof, eof, sop, eop, rem[3:0], data[31:0]} (flags active-high)
// and compared against a beat built from the command and payload words.
// ---------------------------------------------------------------------------
module tb_ll_frame_tx;

  localparam int LEN_W = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ll_frame_tx_if #(.LEN_W(LEN_W)) bus ();

  ll_frame_tx #(.LEN_W(LEN_W)) dut (
    .CPMDMALLCLK (clk),
    .rst_n       (rst_n),
    .bus         (bus)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Bench state
  int          dst_mode = 0;   // 0: sink always ready, 1: toggles 1,0
  int          gap_mode = 0;   // 0: payload always valid, 1: gap every 3rd
  int          dst_ctr  = 0;
  int          gap_ctr  = 0;
  logic [31:0] pq[$];          // payload words still to be handed over
  logic [31:0] pw[$];          // payload words of the current frame
  logic [40:0] beats[$];
  int          beat_edge[$];
  int          accept_edge;
  bit          accepted;
  bit          got_fd;
  bit          prev_stall = 1'b0;
  logic [40:0] prev_pack;
  int          sof_edge, eof_edge;
  logic [31:0] seq_model = '0;

  function automatic logic [40:0] pack();
    return {bus.frame_done, ~bus.LLTXSOFN, ~bus.LLTXEOFN, ~bus.LLTXSOPN,
            ~bus.LLTXEOPN, bus.LLTXREM, bus.LLTXD};
  endfunction

  // Everything visible while reset is held:
  // {srcrdyn, sofn, eofn, sopn, eopn, LLTXD, LLTXREM, cmd_ready, pay_ready, frame_done}
  function automatic logic [43:0] rst_view();
    return {bus.LLTXSRCRDYN, bus.LLTXSOFN, bus.LLTXEOFN, bus.LLTXSOPN,
            bus.LLTXEOPN, bus.LLTXD, bus.LLTXREM, bus.cmd_ready,
            bus.pay_ready, bus.frame_done};
  endfunction

  localparam logic [43:0] RST_EXP = {5'b11111, 32'h0, 4'h0, 3'b000};

  function automatic logic [3:0] exp_rem(input int len);
    case (len % 4)
      1:       return 4'b0111;
      2:       return 4'b0011;
      3:       return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] exp_mask(input int len);
    case (len % 4)
      1:       return 32'hFF00_0000;
      2:       return 32'hFFFF_0000;
      3:       return 32'hFFFF_FF00;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [40:0] exp_beat(input int i, input logic [31:0] flag,
                                           input int len, input logic [31:0] seq);
    int          n;
    logic [31:0] d;
    logic        sof, eof, sop, eop;
    logic [3:0]  rem;
    n   = (len + 3) / 4;
    d   = '0;
    sof = 1'b0; eof = 1'b0; sop = 1'b0; eop = 1'b0; rem = '0;
    if (i < 8) begin
      if (i == 4) d = flag;
      if (i == 5) d = 32'(len);
      if (i == 6) d = seq;
      sof = (i == 0);
      eof = (i == 7) && (len == 0);
    end else begin
      eop = (i - 8 == n - 1);
      sop = (i == 8);
      eof = eop;
      d   = eop ? (pw[i-8] & exp_mask(len)) : pw[i-8];
      rem = eop ? exp_rem(len) : 4'b0000;
    end
    return {eof, sof, eof, sop, eop, rem, d};
  endfunction

  // One clock: sample on the falling edge, drive just after the rising edge.
  task automatic cycle();
    logic [40:0] cur;
    bit          gap;
    @(negedge clk);
    cur = pack();
    if (prev_stall) check("stall_hold", cur, prev_pack);
    prev_stall = !bus.LLTXSRCRDYN && bus.LLTXDSTRDYN;
    prev_pack  = cur;
    if (!bus.LLTXSRCRDYN && !bus.LLTXDSTRDYN) begin
      beats.push_back(cur);
      beat_edge.push_back(cyc + 1);
      if (bus.frame_done) got_fd = 1'b1;
    end
    if (bus.cmd_valid && bus.cmd_ready) begin
      accepted    = 1'b1;
      accept_edge = cyc + 1;
    end
    if (bus.pay_valid && bus.pay_ready) void'(pq.pop_front());
    @(posedge clk);
    #1;
    if (accepted) bus.cmd_valid = 1'b0;
    dst_ctr++;
    bus.LLTXDSTRDYN = (dst_mode == 1) ? ((dst_ctr % 2) == 1) : 1'b0;
    gap_ctr++;
    gap = (gap_mode == 1) && ((gap_ctr % 3) == 0);
    bus.pay_valid = (pq.size() > 0) && !gap;
    bus.pay_data  = (pq.size() > 0) ? pq[0] : 32'h0;
  endtask

  // Offer one command and collect its beats. abort != 0 stops right after
  // the first payload word transfers (the second one is then on the bus).
  task automatic run_frame(input string tag, input logic [31:0] flag,
                           input int len, input bit abort);
    int          n_exp;
    logic [31:0] seq;
`ifdef LL_FRAME_TX_SEQ_EN
    seq = seq_model;
`else
    seq = 32'h0;
`endif
    beats.delete();
    beat_edge.delete();
    got_fd   = 1'b0;
    accepted = 1'b0;
    pq       = pw;
    n_exp    = 8 + (len + 3) / 4;
    bus.cmd_valid = 1'b1;
    bus.cmd_flag  = flag;
    bus.cmd_len   = LEN_W'(len);
    for (int c = 0; c < 400 && !got_fd; c++) begin
      cycle();
      if (abort && beats.size() >= 9) break;
    end
    if (abort) begin
      check({tag, "_pre_abort_beats"}, beats.size(), 9);
      return;
    end
    check({tag, "_frame_done_seen"}, got_fd, 1);
    check({tag, "_beat_count"}, beats.size(), n_exp);
    for (int i = 0; i < n_exp && i < beats.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), beats[i], exp_beat(i, flag, len, seq));
    if (beats.size() > 0) begin
      sof_edge = beat_edge[0];
      eof_edge = beat_edge[beats.size()-1];
      if (dst_mode == 0) check({tag, "_sof_latency"}, sof_edge - accept_edge, 1);
    end
    if (got_fd) seq_model = seq_model + 32'd1;
  endtask

  task automatic reset_outputs_check(input string tag);
    check(tag, rst_view(), RST_EXP);
  endtask

  initial begin
    int prev_eof;
    bus.cmd_valid   = 1'b0;
    bus.cmd_flag    = '0;
    bus.cmd_len     = '0;
    bus.pay_data    = '0;
    bus.pay_valid   = 1'b0;
    bus.LLTXDSTRDYN = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2 reset_outputs_check("reset_values");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("cmd_ready_after_reset", bus.cmd_ready, 1);
    @(posedge clk);
    #1;

    // Copy-op flag, two full payload words, sink always ready.
    pw = '{32'hDEAD_BEEF, 32'h0123_4567};
    run_frame("t1", 32'h2000_0000, 8, 1'b0);

    // Partial last word: one valid byte.
    pw = '{32'hAABB_CCDD, 32'h1122_3344};
    run_frame("t2", 32'h0000_0001, 5, 1'b0);
    if (beats.size() == 10) begin
      check("t2_last_data", beats[9][31:0], 32'h1100_0000);
      check("t2_last_rem", beats[9][35:32], 4'b0111);
    end

    // Header-only frame.
    pw.delete();
    run_frame("t3", 32'hCAFE_0000, 0, 1'b0);

    // Sink toggling plus payload gaps; outputs must hold while stalled.
    dst_mode = 1;
    gap_mode = 1;
    pw = '{32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10};
    run_frame("t4", 32'h2000_0055, 13, 1'b0);
    if (beats.size() == 12) check("t4_last_data", beats[11][31:0], 32'h0D00_0000);
    dst_mode = 0;
    gap_mode = 0;
    repeat (3) cycle();

    // Reset while the second payload word is on the bus.
    pw = '{32'h1111_1111, 32'h2222_2222};
    run_frame("t5", 32'h0, 8, 1'b1);
    rst_n = 1'b0;
    #1 reset_outputs_check("t5_async_reset_values");
    prev_stall    = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.pay_valid = 1'b0;
    pq.delete();
    seq_model = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_cmd_ready_after_reset", bus.cmd_ready, 1);
    @(posedge clk);
    #1;

    // Three back-to-back frames; sequence restarts at 0 after the reset.
    pw = '{32'hA0A0_A0A0};
    run_frame("t6a", 32'h2000_0000, 4, 1'b0);
    prev_eof = eof_edge;
    pw = '{32'hB1B1_B1B1};
    run_frame("t6b", 32'h2000_0000, 4, 1'b0);
    check("t6b_sof_after_eof", sof_edge - prev_eof, 2);
    prev_eof = eof_edge;
    pw = '{32'hC2C2_C2C2};
    run_frame("t6c", 32'h2000_0000, 4, 1'b0);
    check("t6c_sof_after_eof", sof_edge - prev_eof, 2);

    repeat (2) cycle();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
